axi_burst_master: RTL and testbench
===================================

Name: axi_burst_master

Overview:
- Command-driven AXI4 master that issues a single INCR burst per command, write or read, against the integrated SRAM memory controller's slave port.
- Converts a simple command, write-data stream and read-data stream into AW/W/B and AR/R channel traffic with correct wlast, beat counting and response collection.
- Used by test/DMA logic upstream of the controller. One transaction in flight at a time.

Parameters:
- addr_wid_axi, 32, AXI address width.
- data_wid, 32, data bus width; power of two, 8..1024.
- asize, $clog2(data_wid/8), width of awsize/arsize; also the value driven on them (full-width beats).
- stroblen, data_wid/8, strobe width.
- arid_val, 2'b00, constant driven on arid.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  master idle, command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  addr_wid_axi  start byte address.
- cmd_len  in  8  beats-1 (AXI len encoding).
- wr_data  in  data_wid  write beat data.
- wr_strb  in  stroblen  write beat strobes.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat consumed (equals wready while in WDATA).
- rd_data  out  data_wid  read beat data (rdata passthrough).
- rd_resp  out  2  per-beat rresp.
- rd_last  out  1  final beat of burst.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  consumer ready.
- done  out  1  one-cycle pulse at end of transaction.
- done_resp  out  2  transaction response.
- AXI master side, widths identical to the controller slave port: awaddr, awlen, awsize, awburst, awvalid out; awready in; wdata, wstrb, wlast, wvalid out; wready in; bresp, bvalid in; bready out; arid, araddr, arlen, arsize, arburst, arvalid out; arready in; rdata, rresp, rlast, rvalid in; rready out.

Behaviour:
- Reset (aresetn=0, asynchronous):
  - State IDLE; all AXI valids 0, bready 0, rready 0, done 0, done_resp 0, beat counter 0.
  - Registered address/len fields 0. cmd_ready reads 1 after reset.
- Reset mid-burst aborts immediately with no completion pulse. The slave is reset by the same aresetn.
- Command capture: cmd_addr low asize bits are forced to 0 (aligned). awburst/arburst = 2'b01 INCR. awsize/arsize = asize.
- 4KB check: if aligned_addr[11:0] + (cmd_len+1)*stroblen > 4096, issue no AXI traffic. Go to DONE with done_resp=2'b10.
- FSM (state encoding from package):
  - IDLE: cmd_ready=1. On accept, go to WADDR (write), RADDR (read) or DONE (4KB error).
  - WADDR: awvalid=1 with stable fields until awready, then WDATA. AW always completes before any W beat.
  - WDATA: wvalid=wr_valid, wr_ready=wready, wdata/wstrb pass through combinationally from wr_*. wlast=1 when beat counter == awlen. Counter increments on wvalid&&wready. After the last beat handshake, go to WRESP.
  - WRESP: bready=1. On bvalid, done_resp=bresp; go to DONE.
  - RADDR: arvalid=1 until arready, then RDATA.
  - RDATA: rready=rd_ready; rd_* = r* passthrough; rd_valid=rvalid.
    - Counter increments per handshake. done_resp accumulates the maximum rresp seen.
    - The burst ends on the rlast handshake.
    - If the beat count at rlast != arlen+1, or the counter reaches arlen+1 without rlast, done_resp=2'b10. On a missing rlast, stay until rlast.
  - DONE: done=1 for exactly one cycle, then IDLE. done_resp is held until the next command is accepted.
- Valids never deassert before their handshake (AXI stability rule).
- Zero-length commands (cmd_len=0) produce a single beat with wlast/rlast on beat 0.
- Latency: cmd accept to awvalid/arvalid = 1 cycle. Last handshake (B or last R) to done = 1 cycle.
- Back-to-back: a new command is accepted no earlier than the cycle after done.

Decomposition:
- Package axi_pkg holds:
  - burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/EXOKAY/SLVERR/DECERR);
  - the master state enum (IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE);
  - the 4KB boundary constant.
- No sub-module: single FSM with a shared 9-bit beat counter.

Test Plan:
- Write cmd addr=0x100, len=3, data 0xA0..0xA3, strb 0xF, slave ready always -> awaddr=0x100, awlen=3, awburst=01, awsize=2; 4 W beats with wlast only on 0xA3; bresp=00; done pulse with done_resp=00.
- Read cmd addr=0x100, len=3 after the above -> arlen=3, rd_data 0xA0..0xA3, rd_last on the 4th beat, done_resp=00.
- Backpressure: wr_valid gaps plus wready low 2 of every 3 cycles; rd_ready toggling -> data order preserved, no beat lost or duplicated, awvalid/arvalid held stable until ready.
- Unaligned cmd_addr=0x103, len=0 -> awaddr=0x100, single beat with wlast=1.
- cmd_addr=0xFF8, len=3 (crosses 4KB) -> no awvalid/arvalid ever asserted, done pulse with done_resp=10.
- aresetn pulled low mid-WDATA (beat 2 of 4) -> all valids 0 asynchronously, no done; after release cmd_ready=1 and a new write of len=1 completes with done_resp=00.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, master FSM state type and helpers used by the
// command-driven burst master.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] BOUNDARY_4K = 32'd4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WDATA = 3'd2,
        ST_WRESP = 3'd3,
        ST_RADDR = 3'd4,
        ST_RDATA = 3'd5,
        ST_DONE  = 3'd6
    } mst_state_e;

    // Worst-of-two response; the encodings are ordered by severity.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Command-driven AXI4 master: one INCR burst (write or read) per command,
// one transaction in flight, with 4KB-crossing rejection and response collection.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int unsigned addr_wid_axi = 32,
    parameter int unsigned data_wid     = 32,
    parameter int unsigned asize        = $clog2(data_wid / 8),
    parameter int unsigned stroblen     = data_wid / 8,
    parameter logic [1:0]  arid_val     = 2'b00
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [addr_wid_axi-1:0] cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [data_wid-1:0]     wr_data,
    input  logic [stroblen-1:0]     wr_strb,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [data_wid-1:0]     rd_data,
    output logic [1:0]              rd_resp,
    output logic                    rd_last,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    done,
    output logic [1:0]              done_resp,
    output logic [addr_wid_axi-1:0] awaddr,
    output logic [7:0]              awlen,
    output logic [asize-1:0]        awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [data_wid-1:0]     wdata,
    output logic [stroblen-1:0]     wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [1:0]              arid,
    output logic [addr_wid_axi-1:0] araddr,
    output logic [7:0]              arlen,
    output logic [asize-1:0]        arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [data_wid-1:0]     rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam logic [addr_wid_axi-1:0] ADDR_MASK = ~addr_wid_axi'((1 << asize) - 1);

    mst_state_e              state_r, state_s;
    logic [addr_wid_axi-1:0] addr_r;
    logic [7:0]              len_r;
    logic [8:0]              cnt_r;
    logic [1:0]              resp_r;
    logic                    rerr_r;

    logic [addr_wid_axi-1:0] aligned_s;
    logic [31:0]             span_s;
    logic                    cross_s;
    logic                    last_beat_s;
    logic                    w_hs_s;
    logic                    r_hs_s;

    assign aligned_s   = cmd_addr & ADDR_MASK;
    // Byte offset within the 4KB page plus burst bytes; beyond 4096 the burst would cross.
    assign span_s      = {20'd0, aligned_s[11:0]} + ((32'(cmd_len) + 32'd1) * stroblen);
    assign cross_s     = (span_s > BOUNDARY_4K);
    assign last_beat_s = (cnt_r == {1'b0, len_r});
    assign w_hs_s      = (state_r == ST_WDATA) && wr_valid && wready;
    assign r_hs_s      = (state_r == ST_RDATA) && rvalid && rd_ready;

    assign cmd_ready = (state_r == ST_IDLE);
    assign awaddr    = addr_r;
    assign awlen     = len_r;
    assign awsize    = asize'(asize);
    assign awburst   = BURST_INCR;
    assign awvalid   = (state_r == ST_WADDR);
    assign wdata     = wr_data;
    assign wstrb     = wr_strb;
    assign wvalid    = (state_r == ST_WDATA) && wr_valid;
    assign wr_ready  = (state_r == ST_WDATA) && wready;
    assign wlast     = (state_r == ST_WDATA) && last_beat_s;
    assign bready    = (state_r == ST_WRESP);
    assign arid      = arid_val;
    assign araddr    = addr_r;
    assign arlen     = len_r;
    assign arsize    = asize'(asize);
    assign arburst   = BURST_INCR;
    assign arvalid   = (state_r == ST_RADDR);
    assign rready    = (state_r == ST_RDATA) && rd_ready;
    assign rd_data   = rdata;
    assign rd_resp   = rresp;
    assign rd_last   = rlast;
    assign rd_valid  = (state_r == ST_RDATA) && rvalid;
    assign done      = (state_r == ST_DONE);
    assign done_resp = resp_r;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a 4KB-crossing command skips all AXI traffic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cross_s) begin
                        state_s = ST_DONE;
                    end else if (cmd_write) begin
                        state_s = ST_WADDR;
                    end else begin
                        state_s = ST_RADDR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WADDR: state_s = awready ? ST_WDATA : ST_WADDR;
            ST_WDATA: state_s = (w_hs_s && last_beat_s) ? ST_WRESP : ST_WDATA;
            ST_WRESP: state_s = bvalid ? ST_DONE : ST_WRESP;
            ST_RADDR: state_s = arready ? ST_RDATA : ST_RADDR;
            ST_RDATA: state_s = (r_hs_s && rlast) ? ST_DONE : ST_RDATA;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Command capture, shared beat counter and response accumulation.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_r <= '0;
            len_r  <= 8'd0;
            cnt_r  <= 9'd0;
            resp_r <= RESP_OKAY;
            rerr_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_r <= aligned_s;
                        len_r  <= cmd_len;
                        cnt_r  <= 9'd0;
                        rerr_r <= 1'b0;
                        resp_r <= cross_s ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                ST_WDATA: begin
                    if (w_hs_s) begin
                        cnt_r <= cnt_r + 9'd1;
                    end
                end
                ST_WRESP: begin
                    if (bvalid) begin
                        resp_r <= bresp;
                    end
                end
                ST_RDATA: begin
                    if (r_hs_s) begin
                        cnt_r <= cnt_r + 9'd1;
                        // rlast must land exactly on beat len; any other count is a protocol error.
                        if (rlast) begin
                            resp_r <= (rerr_r || !last_beat_s) ? RESP_SLVERR : resp_max(resp_r, rresp);
                        end else begin
                            resp_r <= resp_max(resp_r, rresp);
                            if (last_beat_s) begin
                                rerr_r <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench: AXI slave with configurable backpressure, a write-data
// source, and a byte-level memory model that predicts read data and responses.
module tb_axi_burst_master;

    logic        aclk, aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_last, rd_valid, rd_ready;
    logic        done;
    logic [1:0]  done_resp;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awsize, arsize, awburst, arburst, arid;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, rlast, rvalid, rready;

    axi_burst_master dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .done(done), .done_resp(done_resp),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // stimulus configuration (written only by the main initial block)
    bit          aw_bp, w_bp, ar_bp, r_bp, rd_bp, wsrc_gap;
    int          short_by, err_beat;
    logic [31:0] src_data [0:15];
    logic [3:0]  src_strb [0:15];
    int          src_n;
    logic [31:0] exp_mem [0:1023];

    // slave state
    logic [31:0] mem [0:1023];
    logic [9:0]  w_base, w_idx, r_base;
    logic [8:0]  r_rem;
    int          r_idx, cyc;

    // monitor state
    logic [31:0] wlog_d [0:255];
    logic [3:0]  wlog_s [0:255];
    logic        wlog_l [0:255];
    logic [31:0] rlog_d [0:255];
    logic [1:0]  rlog_r [0:255];
    logic        rlog_l [0:255];
    int          w_n = 0, r_n = 0, aw_n = 0, ar_n = 0, awv_n = 0, arv_n = 0, viol_n = 0;
    logic [31:0] cap_awaddr, cap_araddr, aw_hold, ar_hold, wd_hold;
    logic [7:0]  cap_awlen, cap_arlen;
    logic [1:0]  cap_awsize, cap_awburst, cap_arsize, cap_arburst, cap_arid;
    logic        aw_pend, ar_pend, w_pend, wl_hold;

    int src_idx, src_nx;
    assign src_nx = src_idx + ((wr_valid && wr_ready) ? 1 : 0);

    // AXI slave: random/patterned ready, memory, B response, R beats
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rdata <= 32'd0; rresp <= 2'b00; rlast <= 1'b0;
            w_base <= 10'd0; w_idx <= 10'd0; r_base <= 10'd0; r_rem <= 9'd0;
            r_idx <= 0; cyc <= 0;
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
        end else begin
            cyc     <= cyc + 1;
            awready <= aw_bp ? ($urandom_range(0, 2) == 0) : 1'b1;
            arready <= ar_bp ? ($urandom_range(0, 2) == 0) : 1'b1;
            wready  <= w_bp ? (cyc % 3 == 0) : 1'b1;
            if (awvalid && awready) begin
                w_base <= awaddr[11:2];
                w_idx  <= 10'd0;
            end
            if (wvalid && wready) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) mem[w_base + w_idx][8*b +: 8] <= wdata[8*b +: 8];
                w_idx <= w_idx + 10'd1;
                if (wlast) begin
                    bvalid <= 1'b1;
                    bresp  <= 2'b00;
                end
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                r_base <= araddr[11:2];
                r_rem  <= 9'(int'(arlen) + 1 - short_by);
                r_idx  <= 0;
            end else begin
                if (rvalid && rready) rvalid <= 1'b0;
                if ((!rvalid || rready) && r_rem != 9'd0 && (!r_bp || $urandom_range(0, 1) == 1)) begin
                    rvalid <= 1'b1;
                    rdata  <= mem[r_base + 10'(r_idx)];
                    rresp  <= (r_idx == err_beat) ? 2'b10 : 2'b00;
                    rlast  <= (r_rem == 9'd1);
                    r_idx  <= r_idx + 1;
                    r_rem  <= r_rem - 9'd1;
                end
            end
        end
    end

    // write-data source: holds wr_valid until consumed, optional random gaps
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_valid <= 1'b0; wr_data <= 32'd0; wr_strb <= 4'd0; src_idx <= 0;
        end else if (cmd_valid && cmd_ready) begin
            wr_valid <= 1'b0; src_idx <= 0;
        end else if (!wr_valid || wr_ready) begin
            src_idx <= src_nx;
            if (src_nx < src_n && (!wsrc_gap || $urandom_range(0, 1) == 1)) begin
                wr_valid <= 1'b1;
                wr_data  <= src_data[src_nx];
                wr_strb  <= src_strb[src_nx];
            end else begin
                wr_valid <= 1'b0;
            end
        end
    end

    // read consumer readiness
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rd_ready <= 1'b0;
        else          rd_ready <= rd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // channel monitor: handshake logs, captured fields, stability violations
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_pend <= 1'b0; ar_pend <= 1'b0; w_pend <= 1'b0;
        end else begin
            if (awvalid) awv_n <= awv_n + 1;
            if (arvalid) arv_n <= arv_n + 1;
            if ((aw_pend && !(awvalid && awaddr == aw_hold)) ||
                (ar_pend && !(arvalid && araddr == ar_hold)) ||
                (w_pend && !(wvalid && wdata == wd_hold && wlast == wl_hold)))
                viol_n <= viol_n + 1;
            aw_pend <= awvalid && !awready; aw_hold <= awaddr;
            ar_pend <= arvalid && !arready; ar_hold <= araddr;
            w_pend  <= wvalid && !wready;   wd_hold <= wdata; wl_hold <= wlast;
            if (awvalid && awready) begin
                aw_n <= aw_n + 1; cap_awaddr <= awaddr; cap_awlen <= awlen;
                cap_awsize <= awsize; cap_awburst <= awburst;
            end
            if (arvalid && arready) begin
                ar_n <= ar_n + 1; cap_araddr <= araddr; cap_arlen <= arlen;
                cap_arsize <= arsize; cap_arburst <= arburst; cap_arid <= arid;
            end
            if (wvalid && wready) begin
                wlog_d[w_n[7:0]] <= wdata; wlog_s[w_n[7:0]] <= wstrb; wlog_l[w_n[7:0]] <= wlast;
                w_n <= w_n + 1;
            end
            if (rd_valid && rd_ready) begin
                rlog_d[r_n[7:0]] <= rd_data; rlog_r[r_n[7:0]] <= rd_resp; rlog_l[r_n[7:0]] <= rd_last;
                r_n <= r_n + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a command, report AXI valid one cycle after accept, then await done.
    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                           output logic lat_v, output logic [1:0] resp);
        int   t;
        logic seen;
        t = 0;
        @(negedge aclk);
        while (!cmd_ready && t < 50) begin @(negedge aclk); t++; end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        @(negedge aclk);
        cmd_valid = 1'b0;
        lat_v = wr ? awvalid : arvalid;
        seen = 1'b0; resp = 2'bxx; t = 0;
        while (!seen && t < 3000) begin
            if (done) begin seen = 1'b1; resp = done_resp; end
            else begin @(negedge aclk); t++; end
        end
        chk("done_seen", seen, 1'b1);
        @(negedge aclk);
        chk("done_one_cycle", done, 1'b0);
    endtask

    task automatic load_src(input int n, input bit rnd, input logic [31:0] base_d);
        for (int i = 0; i < n; i++) begin
            src_data[i] = rnd ? $urandom : base_d + 32'(i);
            src_strb[i] = rnd ? 4'($urandom_range(1, 15)) : 4'hF;
        end
        src_n = n;
    endtask

    task automatic model_write(input logic [31:0] addr, input int n);
        int wa;
        wa = int'(addr[11:2]);
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++)
                if (src_strb[i][b]) exp_mem[wa + i][8*b +: 8] = src_data[i][8*b +: 8];
    endtask

    task automatic check_w(input int base, input int n);
        chk("w_beat_count", 32'(w_n - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk("w_data", wlog_d[base + i], src_data[i]);
            chk("w_strb", wlog_s[base + i], src_strb[i]);
            chk("w_last", wlog_l[base + i], (i == n - 1));
        end
    endtask

    task automatic check_r(input int base, input logic [31:0] addr, input int n);
        int wa;
        wa = int'(addr[11:2]);
        chk("r_beat_count", 32'(r_n - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk("r_data", rlog_d[base + i], exp_mem[wa + i]);
            chk("r_last", rlog_l[base + i], (i == n - 1));
        end
    endtask

    initial begin
        logic        lv;
        logic [1:0]  rs;
        logic [31:0] a;
        int          wb, rb, n, v0, awv0, arv0;

        aw_bp = 0; w_bp = 0; ar_bp = 0; r_bp = 0; rd_bp = 0; wsrc_gap = 0;
        short_by = 0; err_beat = -1; src_n = 0;
        for (int i = 0; i < 1024; i++) exp_mem[i] = 32'd0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 32'd0; cmd_len = 8'd0;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_done_resp", done_resp, 2'b00);
        chk("rst_awaddr", awaddr, 32'd0);
        chk("rst_awlen", awlen, 8'd0);
        aresetn = 1'b1;

        // basic write 0x100 len 3
        load_src(4, 0, 32'hA0); wb = w_n;
        run_cmd(1'b1, 32'h100, 8'd3, lv, rs);
        model_write(32'h100, 4);
        chk("wr_latency", lv, 1'b1);
        chk("awaddr", cap_awaddr, 32'h100);
        chk("awlen", cap_awlen, 8'd3);
        chk("awburst", cap_awburst, 2'b01);
        chk("awsize", cap_awsize, 2'd2);
        check_w(wb, 4);
        chk("wr_done_resp", rs, 2'b00);
        chk("done_resp_held", done_resp, 2'b00);

        // read back
        src_n = 0; rb = r_n;
        run_cmd(1'b0, 32'h100, 8'd3, lv, rs);
        chk("rd_latency", lv, 1'b1);
        chk("araddr", cap_araddr, 32'h100);
        chk("arlen", cap_arlen, 8'd3);
        chk("arsize", cap_arsize, 2'd2);
        chk("arburst", cap_arburst, 2'b01);
        chk("arid", cap_arid, 2'b00);
        check_r(rb, 32'h100, 4);
        chk("rd_done_resp", rs, 2'b00);

        // randomized bursts under backpressure
        v0 = viol_n;
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, 16);
            a = 32'h200 + 32'($urandom_range(0, 63)) * 32'd4;
            aw_bp = 1; w_bp = 1; wsrc_gap = 1; ar_bp = 0; r_bp = 0; rd_bp = 0;
            load_src(n, 1, 32'd0); wb = w_n;
            run_cmd(1'b1, a, 8'(n - 1), lv, rs);
            model_write(a, n);
            chk("bp_wr_latency", lv, 1'b1);
            check_w(wb, n);
            chk("bp_wr_resp", rs, 2'b00);
            aw_bp = 0; w_bp = 0; wsrc_gap = 0; ar_bp = 1; r_bp = 1; rd_bp = 1;
            src_n = 0; rb = r_n;
            run_cmd(1'b0, a, 8'(n - 1), lv, rs);
            check_r(rb, a, n);
            chk("bp_rd_resp", rs, 2'b00);
        end
        ar_bp = 0; r_bp = 0; rd_bp = 0;
        chk("valid_stability", 32'(viol_n - v0), 32'd0);

        // unaligned single-beat write
        load_src(1, 0, 32'h55AA55AA); wb = w_n;
        run_cmd(1'b1, 32'h103, 8'd0, lv, rs);
        model_write(32'h100, 1);
        chk("unaligned_awaddr", cap_awaddr, 32'h100);
        check_w(wb, 1);
        chk("unaligned_resp", rs, 2'b00);

        // 4KB crossing: no AXI traffic, SLVERR
        awv0 = awv_n; arv0 = arv_n; wb = w_n;
        load_src(4, 0, 32'hC0);
        run_cmd(1'b1, 32'hFF8, 8'd3, lv, rs);
        chk("x4k_wr_resp", rs, 2'b10);
        chk("x4k_wr_latency", lv, 1'b0);
        src_n = 0;
        run_cmd(1'b0, 32'hFF8, 8'd3, lv, rs);
        chk("x4k_rd_resp", rs, 2'b10);
        chk("x4k_awvalid_cycles", 32'(awv_n - awv0), 32'd0);
        chk("x4k_arvalid_cycles", 32'(arv_n - arv0), 32'd0);
        chk("x4k_w_beats", 32'(w_n - wb), 32'd0);

        // burst ending exactly at the 4KB boundary is legal
        load_src(4, 1, 32'd0); wb = w_n;
        run_cmd(1'b1, 32'hFF0, 8'd3, lv, rs);
        model_write(32'hFF0, 4);
        chk("edge4k_resp", rs, 2'b00);
        check_w(wb, 4);

        // SLVERR on one read beat -> worst response reported
        err_beat = 1; src_n = 0; rb = r_n;
        run_cmd(1'b0, 32'h100, 8'd3, lv, rs);
        chk("rresp_max", rs, 2'b10);
        chk("rresp_beat1", rlog_r[rb + 1], 2'b10);
        err_beat = -1;

        // early rlast -> beat-count error
        short_by = 1; rb = r_n;
        run_cmd(1'b0, 32'h100, 8'd3, lv, rs);
        chk("early_rlast_resp", rs, 2'b10);
        chk("early_rlast_beats", 32'(r_n - rb), 32'd3);
        short_by = 0;

        // reset in the middle of a write burst
        load_src(4, 0, 32'hD0); wb = w_n;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_len = 8'd3;
        @(negedge aclk);
        cmd_valid = 1'b0;
        n = 0;
        while (w_n - wb < 2 && n < 100) begin @(negedge aclk); n++; end
        chk("mid_beats_before_reset", 32'(w_n - wb), 32'd2);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_awvalid", awvalid, 1'b0);
        chk("mid_rst_wvalid", wvalid, 1'b0);
        chk("mid_rst_bready", bready, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 1024; i++) exp_mem[i] = 32'd0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin @(negedge aclk); if (done) n++; end
        chk("no_done_after_abort", 32'(n), 32'd0);
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        load_src(2, 1, 32'd0); wb = w_n;
        run_cmd(1'b1, 32'h300, 8'd1, lv, rs);
        model_write(32'h300, 2);
        check_w(wb, 2);
        chk("post_rst_resp", rs, 2'b00);
        src_n = 0; rb = r_n;
        run_cmd(1'b0, 32'h300, 8'd1, lv, rs);
        check_r(rb, 32'h300, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
